// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time through an external combinational ALU, with a
// multi-pass shift mode that is enabled by defining ALU_SEQ_SHIFTN_EN.
module alu_op_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_cnt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b1011,
            4'b1100, 4'b1000, 4'b0110: is_legal = 1'b1;
            default:                   is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        is_shift = (op == 4'b1011) || (op == 4'b1100);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic [2:0]        cnt_eff;

    // Non-shift ops always take exactly one pass, whatever req_cnt says.
`ifdef ALU_SEQ_SHIFTN_EN
    assign cnt_eff = is_shift(req_op) ? req_cnt : 3'd1;
`else
    logic unused_req_cnt;
    assign unused_req_cnt = ^req_cnt;
    assign cnt_eff        = 3'd1;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    a_d   = req_a;
                    b_d   = req_b;
                    cnt_d = cnt_eff;
                    if (!is_legal(req_op)) begin
                        state_d = S_DONE;
                        data_d  = '0;
                        carry_d = 1'b0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (cnt_eff == 3'd0) begin
                        // Zero-pass shift returns the operand untouched.
                        state_d = S_DONE;
                        data_d  = req_a;
                        carry_d = 1'b0;
                        zero_d  = (req_a == '0);
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (is_shift(op_q) && (cnt_q > 3'd1)) begin
                    a_d   = alu_out;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = S_DONE;
                    data_d  = alu_out;
                    carry_d = alu_carry;
                    zero_d  = (alu_out == '0);
                    err_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign alu_a     = (state_q == S_EXEC) ? a_q  : '0;
    assign alu_b     = (state_q == S_EXEC) ? b_q  : '0;
    assign alu_sel   = (state_q == S_EXEC) ? op_q : 4'd0;
    assign rsp_data  = data_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;

endmodule
